// File: rtl/stump_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the Stump bus: TXDATA/STATUS registers,
// a 4-deep byte FIFO and a registered serial shifter with back-to-back framing.
module stump_uart_tx #(
    parameter logic [15:0] BASE_ADDR    = 16'hFF00,
    parameter int          CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] address,
    input  logic [15:0] data_out,
    input  logic        mem_wen,
    input  logic        mem_ren,
    output logic [15:0] rd_data,
    output logic        sel,
    output logic        txd
);

    localparam logic [15:0] STAT_ADDR = BASE_ADDR + 16'd1;
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state_q;
    logic [7:0]  fifo_q [4];
    logic [1:0]  wptr_q;
    logic [1:0]  rptr_q;
    logic [2:0]  count_q;
    logic [2:0]  count_d;
    logic        overrun_q;
    logic        overrun_d;
    logic [7:0]  shift_q;
    logic [2:0]  bit_q;
    logic [15:0] baud_q;
    logic        txd_q;

    logic        hit_tx;
    logic        hit_stat;
    logic        push_req;
    logic        push_ok;
    logic        pop;
    logic        baud_end;
    logic        full;
    logic        empty;
    logic        busy;
    logic [15:0] status;
    logic        unused_data_hi;

    assign hit_tx   = (address == BASE_ADDR);
    assign hit_stat = (address == STAT_ADDR);
    assign sel      = hit_tx | hit_stat;

    assign full     = (count_q == 3'd4);
    assign empty    = (count_q == 3'd0);
    assign busy     = (state_q != IDLE);
    assign baud_end = (baud_q == BAUD_LAST);

    // Pops are decided from the registered count only, so a byte pushed this
    // edge is never popped on the same edge.
    assign pop      = !empty && ((state_q == IDLE) || ((state_q == STOP) && baud_end));
    assign push_req = mem_wen && hit_tx;
    assign push_ok  = push_req && (!full || pop);

    assign status   = {9'b0, count_q, overrun_q, busy, empty, full};
    assign rd_data  = hit_stat ? status : 16'h0000;
    assign txd      = txd_q;

    assign unused_data_hi = ^data_out[15:8];

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 3'd1;
        end else if (!push_ok && pop) begin
            count_d = count_q - 3'd1;
        end

        // A dropped write on the same edge as a STATUS read leaves the flag set.
        overrun_d = overrun_q;
        if (mem_ren && hit_stat) begin
            overrun_d = 1'b0;
        end
        if (push_req && !push_ok) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_q[wptr_q] <= data_out[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr_q <= wptr_q + 2'd1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 2'd1;
            end
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            txd_q   <= 1'b1;
            shift_q <= '0;
            bit_q   <= '0;
            baud_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    txd_q <= 1'b1;
                    if (pop) begin
                        shift_q <= fifo_q[rptr_q];
                        baud_q  <= '0;
                        txd_q   <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        txd_q   <= shift_q[0];
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= shift_q >> 1;
                            txd_q   <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        // Queued data goes straight into the next start bit.
                        if (pop) begin
                            shift_q <= fifo_q[rptr_q];
                            txd_q   <= 1'b0;
                            state_q <= START;
                        end else begin
                            txd_q   <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                default: begin
                    txd_q   <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/stump_uart_tx.md
STUMP_UART_TX -- requirements
Module: stump_uart_tx

Interface
REQ-001 Parameter BASE_ADDR, default 16'hFF00, word address of TXDATA; STATUS is BASE_ADDR+1.
REQ-002 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range 2..65535.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 address  input  16  Stump bus address.
REQ-006 data_out  input  16  Stump write data; only bits [7:0] used.
REQ-007 mem_wen  input  1  Stump memory write enable.
REQ-008 mem_ren  input  1  Stump memory read enable.
REQ-009 rd_data  output  16  read data to the Stump data_in mux.
REQ-010 sel  output  1  high while address equals BASE_ADDR or BASE_ADDR+1; combinational; the top level uses it to steer data_in.
REQ-011 txd  output  1  serial line, idle high, 8N1, LSB first.

Function
REQ-012 Block SHALL hold a 4-entry x 8-bit FIFO with a 3-bit occupancy count (0..4), write/read pointers wrapping modulo 4.
REQ-013 Push: rising edge with mem_wen=1 and address=BASE_ADDR SHALL push data_out[7:0] if count<4.
REQ-014 Push with count=4 and no same-cycle pop SHALL be dropped, FIFO unchanged, sticky overrun flag set.
REQ-015 Push with count=4 and same-cycle pop SHALL be accepted; count stays 4, no overrun.
REQ-016 STATUS read value: bit0 full (count=4), bit1 empty (count=0), bit2 busy (FSM not IDLE), bit3 overrun, bits[6:4] count, bits[15:7] zero.
REQ-017 rd_data SHALL be combinational: STATUS value when address=BASE_ADDR+1, else 16'h0000 (including TXDATA reads).
REQ-018 Rising edge with mem_ren=1 and address=BASE_ADDR+1 SHALL clear overrun; an overrun-setting write on the same edge wins (flag set).
REQ-019 mem_wen to STATUS SHALL have no effect.
REQ-020 FSM states IDLE, START, DATA, STOP; one bit counter (0..7), one baud counter (0..CLKS_PER_BIT-1).
REQ-021 IDLE: txd=1; if registered count>0 on an edge, pop head into shift register, go START, baud counter=0.
REQ-022 START: txd=0 for CLKS_PER_BIT cycles, then DATA with bit counter=0.
REQ-023 DATA: txd=shift[0]; after CLKS_PER_BIT cycles shift right; after bit 7 go STOP.
REQ-024 STOP: txd=1 for CLKS_PER_BIT cycles; at end, if count>0 pop and go directly to START (back-to-back, no idle gap), else IDLE.
REQ-025 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles.
REQ-026 Latency: push on edge N into empty idle FIFO -> pop and START on edge N+1; txd falls after edge N+1.
REQ-027 Pop decision SHALL use registered count only; a push into an empty FIFO is never popped on the same edge.
REQ-028 txd SHALL be registered (glitch-free).

Reset
REQ-029 rst low SHALL immediately force: FSM IDLE, txd=1, count=0, pointers=0, overrun=0, counters=0; FIFO contents need not clear.
REQ-030 Reset asserted mid-frame SHALL abort the frame and discard all queued bytes; after release txd stays 1 until a new push.
REQ-031 After reset release, STATUS SHALL read 16'h0002.

Verification (CLKS_PER_BIT=4)
REQ-032 Write 16'h1255 to FF00 -> txd: 0 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4; total 40 cycles; STATUS busy clears after.
REQ-033 Write 5 bytes back-to-back while idle -> first popped after one edge, 4 queued, none dropped; write 6th immediately -> overrun=1, STATUS bit3=1; read STATUS -> overrun cleared next read.
REQ-034 Queue 3 bytes -> three frames contiguous, 120 cycles, no txd high gap beyond stop bits.
REQ-035 Push while full on exact STOP-end pop edge -> accepted, count stays 4, overrun=0.
REQ-036 Assert rst at cycle 15 of a frame with 2 queued -> txd=1 immediately, STATUS=16'h0002 after release, no further frames.
REQ-037 Read FF00 and FF02 -> rd_data=0, sel=1 then 0; write FF01 -> no state change.
